alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a registered result stage and valid/ready
// handshakes on both sides. Logic ops, XOR, ADD and SUB complete in one
// cycle; MUL is an iterative shift-add taking WIDTH cycles in its own state.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Input side: in_valid/in_ready; output side: out_valid/out_ready.
// out_valid never depends combinationally on out_ready; in_ready may follow
// out_ready in the same cycle so that one result per cycle can be sustained.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic [1:0]       state_dbg
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FULL = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Goes high on the first edge after reset release; holds in_ready low
  // until then so nothing is accepted while reset is still settling.
  logic run_q;

  logic accept;
  logic is_mul;
  logic mul_done;

  // Single-cycle ALU path
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_ovf;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  // Shift-add multiplier state
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]   cnt_q;

  // With MUL_EN=0 opcode 111 falls through to the single-cycle AND path.
  assign is_mul    = MUL_EN && (opcode == OP_MUL);
  assign mul_done  = (state_q == ST_MUL) && (cnt_q == CNT_LAST);
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
  assign out_valid = (state_q == ST_FULL);
  assign state_dbg = state_q;

  // Single-cycle result and flags for every op except an enabled MUL.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    sum_ext   = {1'b0, a} + {1'b0, b};
    diff_ext  = {1'b0, a} - {1'b0, b};
    case (opcode)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_XOR:  alu_res = a ^ b;
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      default: alu_res = a & b;
    endcase
    // Opcode 111 on this path only occurs with MUL disabled: all flags 0.
    alu_zero = (opcode != OP_MUL) && (alu_res == '0);
  end

  // Next-state, in_ready and accept decode.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = run_q;
      ST_FULL: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = is_mul ? ST_MUL : ST_FULL;
      end
      ST_FULL: begin
        if (accept)         state_d = is_mul ? ST_MUL : ST_FULL;
        else if (out_ready) state_d = ST_IDLE;
      end
      ST_MUL: begin
        if (mul_done) state_d = ST_FULL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Post-reset run enable for in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Output register: loaded by a single-cycle accept or by MUL completion;
  // otherwise holds its last value (also after it has been consumed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
    end else if (accept && !is_mul) begin
      result     <= alu_res;
      flag_zero  <= alu_zero;
      flag_carry <= alu_carry;
      flag_ovf   <= alu_ovf;
    end else if (mul_done) begin
      result     <= acc_next[WIDTH-1:0];
      flag_zero  <= (acc_next[WIDTH-1:0] == '0);
      flag_carry <= |acc_next[2*WIDTH-1:WIDTH];
      flag_ovf   <= 1'b0;
    end
  end

  // Shift-add multiplier: one multiplier bit per MUL cycle, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == ST_MUL) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8, MUL enabled) with an expected-result
// queue filled on input acceptance and drained on output transfers.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;
  logic [1:0]   state_dbg;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard state: entry = {result, zero, carry, ovf}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] pend;
  logic [W+2:0] saved;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int last_out_cyc = 0;
  int out_cnt = 0;
  bit acc_flag = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model, written with plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    int ux, uy, sx, sy, r;
    logic [W-1:0] res;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = $signed(x);
    sy = $signed(y);
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      3'd0: res = x & y;
      3'd1: res = x | y;
      3'd2: res = ~(x & y);
      3'd3: res = ~(x | y);
      3'd4: res = x ^ y;
      3'd5: begin
        r = ux + uy;
        res = r[W-1:0];
        c = (r >= (1 << W));
        v = ((sx + sy) > 127) || ((sx + sy) < -128);
      end
      3'd6: begin
        r = ux - uy;
        res = r[W-1:0];
        c = (ux < uy);
        v = ((sx - sy) > 127) || ((sx - sy) < -128);
      end
      default: begin
        r = ux * uy;
        res = r[W-1:0];
        c = (r >= (1 << W));
      end
    endcase
    return {res, (res == '0), c, v};
  endfunction

  // Output monitor, called mid-cycle from tick().
  task automatic mon();
    logic [W+2:0] got;
    logic [W+2:0] e;
    if (out_valid && out_ready) begin
      out_cnt++;
      last_out_cyc = cyc;
      got = {result, flag_zero, flag_carry, flag_ovf};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_out observed=%0h expected=none", got);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(got), 32'(e));
      end
    end
  endtask

  // One clock: sample at negedge, return 1 time unit after the next posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    mon();
    acc_flag = in_valid && in_ready;
    if (acc_flag) begin
      exp_q.push_back(pend);
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    opcode = 3'($urandom_range(0, 7));
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    opcode = op;
    a = x;
    b = y;
    in_valid = 1'b1;
    pend = model(op, x, y);
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_flag && n < 40);
    if (!acc_flag) chk("accept_timeout", 32'(acc_flag), 32'd1);
    in_valid = 1'b0;
    junk();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int a1, n_ov, o0;
    logic [2:0] arith_op[4];
    logic [W-1:0] arith_a[4];
    logic [W-1:0] arith_b[4];

    // Reset with random inputs
    rst_n = 1'b0;
    in_valid = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    junk();
    pend = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      junk();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_flags", 32'({flag_zero, flag_carry, flag_ovf}), 32'd0);
    end
    chk("rst_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Logic ops, one at a time, latency 1
    for (int op = 0; op < 5; op++) begin
      send(3'(op), 8'hF0, 8'h3C);
      drain();
      chk("logic_latency", 32'(last_out_cyc - last_acc_cyc), 32'd1);
    end

    // Arithmetic edge cases
    arith_op = '{3'd5, 3'd5, 3'd6, 3'd6};
    arith_a  = '{8'h7F, 8'hFF, 8'h80, 8'h05};
    arith_b  = '{8'h01, 8'h01, 8'h01, 8'h07};
    for (int i = 0; i < 4; i++) begin
      send(arith_op[i], arith_a[i], arith_b[i]);
      drain();
      chk("arith_latency", 32'(last_out_cyc - last_acc_cyc), 32'd1);
    end

    // MUL: in_ready low and out_valid low for all WIDTH multiply cycles
    send(3'd7, 8'h0F, 8'h11);
    chk("mul_in_ready", 32'(in_ready), 32'd0);
    chk("mul_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < W - 1; i++) begin
      tick();
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      chk("mul_out_valid", 32'(out_valid), 32'd0);
    end
    drain();
    chk("mul_latency", 32'(last_out_cyc - last_acc_cyc), 32'(W + 1));
    send(3'd7, 8'h10, 8'h10);
    drain();
    chk("mul_latency", 32'(last_out_cyc - last_acc_cyc), 32'(W + 1));

    // Throughput: four back-to-back ADDs
    o0 = out_cnt;
    send(3'd5, 8'h01, 8'h02);
    a1 = last_acc_cyc;
    send(3'd5, 8'h80, 8'h80);
    send(3'd5, 8'hC0, 8'h50);
    send(3'd5, 8'h33, 8'h44);
    chk("stream_accepts", 32'(last_acc_cyc - a1), 32'd3);
    drain();
    chk("stream_outputs", 32'(out_cnt - o0), 32'd4);
    chk("stream_last_latency", 32'(last_out_cyc - last_acc_cyc), 32'd1);

    // Backpressure: result held, new input refused while out_ready=0
    out_ready = 1'b0;
    send(3'd5, 8'h11, 8'h22);
    saved = model(3'd5, 8'h11, 8'h22);
    opcode = 3'd6;
    a = 8'h40;
    b = 8'h41;
    in_valid = 1'b1;
    pend = model(3'd6, 8'h40, 8'h41);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_result", 32'(result), 32'(saved[W+2:3]));
      chk("hold_flags", 32'({flag_zero, flag_carry, flag_ovf}), 32'(saved[2:0]));
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    junk();
    drain();
    chk("release_latency", 32'(last_out_cyc - last_acc_cyc), 32'd1);

    // Reset in MUL cycle 4: operation discarded
    send(3'd7, 8'h0F, 8'h11);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    n_ov = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) n_ov++;
    end
    chk("abort_no_valid", 32'(n_ov), 32'd0);
    send(3'd5, 8'h12, 8'h34);
    drain();
    chk("post_abort_latency", 32'(last_out_cyc - last_acc_cyc), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
